// File: rtl/gcn_pkg.sv
// Shared constants and types for the GCN input server: memory map, stream
// length, FSM states and the packed row/answer shapes.
package gcn_pkg;

  localparam int FEATURE_ROWS      = 6;
  localparam int WEIGHT_ROWS       = 96;
  localparam int WEIGHT_COLS       = 3;
  localparam int ELEM_WIDTH        = 5;
  localparam int ADDRESS_WIDTH     = 13;
  localparam int FEATURE_BASE      = 512;
  localparam int COO_NUM_OF_COLS   = 6;
  localparam int COO_BW            = $clog2(COO_NUM_OF_COLS);
  localparam int MAX_ADDRESS_WIDTH = 2;

  // Weight columns and feature rows share one row store, in stream order.
  localparam int NUM_ROWS = WEIGHT_COLS + FEATURE_ROWS;
  localparam int ROW_BW   = $clog2(NUM_ROWS + 3);
  localparam int ELEM_BW  = $clog2(WEIGHT_ROWS);
  localparam int TOTAL    = WEIGHT_ROWS * WEIGHT_COLS + WEIGHT_ROWS * FEATURE_ROWS
                            + 2 * COO_NUM_OF_COLS;
  localparam int COUNT_BW = $clog2(TOTAL);

  typedef enum logic [1:0] {LOAD, START, RUN, HOLD} state_t;

  typedef logic [0:WEIGHT_ROWS-1][ELEM_WIDTH-1:0] row_t;

endpackage

// File: rtl/gcn_row_store.sv
// Row storage for weight columns and feature rows: element-granular writes,
// registered full-row reads with out-of-map detection.
module gcn_row_store
  import gcn_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    wr_en,
  input  logic [ROW_BW-1:0]                       wr_row,
  input  logic [ELEM_BW-1:0]                      wr_elem,
  input  logic [ELEM_WIDTH-1:0]                   wr_data,
  input  logic                                    rd_en,
  input  logic [ADDRESS_WIDTH-1:0]                rd_addr,
  output logic [0:WEIGHT_ROWS-1][ELEM_WIDTH-1:0]  rd_data,
  output logic                                    rd_error
);

  row_t                     mem [0:NUM_ROWS-1];
  logic                     hit;
  logic [ROW_BW-1:0]        hit_row;
  logic [ADDRESS_WIDTH-1:0] feat_off;

  // Weight column c lives at address c, feature row r at FEATURE_BASE + r.
  always_comb begin
    hit      = 1'b0;
    hit_row  = '0;
    feat_off = rd_addr - ADDRESS_WIDTH'(FEATURE_BASE);
    if (rd_addr < ADDRESS_WIDTH'(WEIGHT_COLS)) begin
      hit     = 1'b1;
      hit_row = ROW_BW'(rd_addr);
    end else if (rd_addr >= ADDRESS_WIDTH'(FEATURE_BASE) &&
                 feat_off < ADDRESS_WIDTH'(FEATURE_ROWS)) begin
      hit     = 1'b1;
      hit_row = ROW_BW'(feat_off) + ROW_BW'(WEIGHT_COLS);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row][wr_elem] <= wr_data;
    end
  end

  // Same-edge reads see the contents from before that edge's write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_error <= 1'b0;
    end else if (rd_en) begin
      if (hit) begin
        rd_data <= mem[hit_row];
      end else begin
        rd_data  <= '0;
        rd_error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcn_input_server.sv
// Loads weights, features and the COO list from a serial stream, starts GCN,
// serves its row/COO reads and holds its argmax answers until acknowledged.
module gcn_input_server
  import gcn_pkg::*;
(
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            load_valid,
  input  logic [ELEM_WIDTH-1:0]                           load_data,
  output logic                                            load_ready,
  output logic                                            gcn_start,
  input  logic                                            gcn_enable_read,
  input  logic [ADDRESS_WIDTH-1:0]                        gcn_read_address,
  output logic [0:WEIGHT_ROWS-1][ELEM_WIDTH-1:0]          gcn_data_in,
  input  logic [COO_BW-1:0]                               gcn_coo_address,
  output logic [0:1][COO_BW-1:0]                          gcn_coo_in,
  input  logic                                            gcn_done,
  input  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]  gcn_max_addi_answer,
  output logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]  result,
  output logic                                            result_valid,
  input  logic                                            result_ack,
  output logic                                            addr_error
);

  state_t              state, state_next;
  logic [COUNT_BW-1:0] load_count;
  logic [ROW_BW-1:0]   row_idx;
  logic [ELEM_BW-1:0]  elem_idx;
  logic [COO_BW-1:0]   coo_row0 [0:COO_NUM_OF_COLS-1];
  logic [COO_BW-1:0]   coo_row1 [0:COO_NUM_OF_COLS-1];
  logic                beat, last_beat, row_wrap, row_wr_en;
  logic                done_q, done_rise;
  logic                coo_in_range, coo_error, row_error;

  assign beat      = (state == LOAD) && load_valid;
  assign last_beat = beat && (load_count == COUNT_BW'(TOTAL - 1));
  assign done_rise = gcn_done && !done_q;
  assign row_wr_en = beat && (row_idx < ROW_BW'(NUM_ROWS));

  // Rows past the row store are the two COO rows, each only COO_NUM_OF_COLS long.
  assign row_wrap = (row_idx < ROW_BW'(NUM_ROWS))
                    ? (elem_idx == ELEM_BW'(WEIGHT_ROWS - 1))
                    : (elem_idx == ELEM_BW'(COO_NUM_OF_COLS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (last_beat)  state_next = START;
      START:                   state_next = RUN;
      RUN:     if (done_rise)  state_next = HOLD;
      HOLD:    if (result_ack) state_next = LOAD;
      default:                 state_next = LOAD;
    endcase
  end

  always_comb begin
    load_ready   = (state == LOAD);
    gcn_start    = (state == START);
    result_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_count <= '0;
      row_idx    <= '0;
      elem_idx   <= '0;
    end else if (state == HOLD && result_ack) begin
      load_count <= '0;
      row_idx    <= '0;
      elem_idx   <= '0;
    end else if (beat) begin
      load_count <= load_count + 1'b1;
      if (row_wrap) begin
        elem_idx <= '0;
        row_idx  <= row_idx + 1'b1;
      end else begin
        elem_idx <= elem_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat && row_idx == ROW_BW'(NUM_ROWS)) begin
      coo_row0[elem_idx[COO_BW-1:0]] <= load_data[COO_BW-1:0];
    end
    if (beat && row_idx == ROW_BW'(NUM_ROWS + 1)) begin
      coo_row1[elem_idx[COO_BW-1:0]] <= load_data[COO_BW-1:0];
    end
  end

  assign coo_in_range = int'(gcn_coo_address) < COO_NUM_OF_COLS;

  always_comb begin
    gcn_coo_in = '0;
    if (coo_in_range) begin
      gcn_coo_in[0] = coo_row0[gcn_coo_address];
      gcn_coo_in[1] = coo_row1[gcn_coo_address];
    end
  end

  // done_q tracks gcn_done in every state so a level left high from a prior run is no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q    <= 1'b0;
      coo_error <= 1'b0;
      result    <= '0;
    end else begin
      done_q <= gcn_done;
      if (!coo_in_range) begin
        coo_error <= 1'b1;
      end
      if (state == RUN && done_rise) begin
        result <= gcn_max_addi_answer;
      end
    end
  end

  assign addr_error = row_error | coo_error;

  gcn_row_store u_row_store (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (row_wr_en),
    .wr_row   (row_idx),
    .wr_elem  (elem_idx),
    .wr_data  (load_data),
    .rd_en    (gcn_enable_read),
    .rd_addr  (gcn_read_address),
    .rd_data  (gcn_data_in),
    .rd_error (row_error)
  );

endmodule

// File: tb/tb_gcn_input_server.sv
// Self-checking bench for gcn_input_server: a stream/map-level model checked
// every cycle, plus directed literal checks on loads, reads, capture and reset.
module tb_gcn_input_server;
  import gcn_pkg::*;

  logic                                            clk;
  logic                                            reset;
  logic                                            load_valid;
  logic [ELEM_WIDTH-1:0]                           load_data;
  logic                                            load_ready;
  logic                                            gcn_start;
  logic                                            gcn_enable_read;
  logic [ADDRESS_WIDTH-1:0]                        gcn_read_address;
  logic [0:WEIGHT_ROWS-1][ELEM_WIDTH-1:0]          gcn_data_in;
  logic [COO_BW-1:0]                               gcn_coo_address;
  logic [0:1][COO_BW-1:0]                          gcn_coo_in;
  logic                                            gcn_done;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]  gcn_max_addi_answer;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]  result;
  logic                                            result_valid;
  logic                                            result_ack;
  logic                                            addr_error;

  int tests_run    = 0;
  int tests_failed = 0;
  int start_pulses = 0;

  gcn_input_server dut (
    .clk                 (clk),
    .reset               (reset),
    .load_valid          (load_valid),
    .load_data           (load_data),
    .load_ready          (load_ready),
    .gcn_start           (gcn_start),
    .gcn_enable_read     (gcn_enable_read),
    .gcn_read_address    (gcn_read_address),
    .gcn_data_in         (gcn_data_in),
    .gcn_coo_address     (gcn_coo_address),
    .gcn_coo_in          (gcn_coo_in),
    .gcn_done            (gcn_done),
    .gcn_max_addi_answer (gcn_max_addi_answer),
    .result              (result),
    .result_valid        (result_valid),
    .result_ack          (result_ack),
    .addr_error          (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ELEM_WIDTH-1:0] elem_value(input int k, input int seed);
    int j;
    if (k < 288) return ELEM_WIDTH'(((k / 96) + (k % 96) + seed) % 32);
    if (k < 864) return ELEM_WIDTH'((7 + seed) % 32);
    j = k - 864;
    if (j < 6) return ELEM_WIDTH'(j);
    return ELEM_WIDTH'((j - 5) % 6);
  endfunction

  // Model: phase 0=loading, 1=start pulse, 2=GCN running, 3=holding answers.
  int   m_phase, m_beats, m_a, m_k, cmp_a;
  int   m_wm  [3][96];
  int   m_fm  [6][96];
  int   m_coo [2][6];
  row_t m_data;
  bit   m_err, m_prev_done;
  logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0] m_result;

  initial begin
    foreach (m_coo[r, c]) m_coo[r][c] = -1;
    foreach (m_wm[r, c])  m_wm[r][c]  = 0;
    foreach (m_fm[r, c])  m_fm[r][c]  = 0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase     = 0;
      m_beats     = 0;
      m_data      = '0;
      m_err       = 1'b0;
      m_result    = '0;
      m_prev_done = 1'b0;
    end else begin
      if (gcn_enable_read) begin
        m_a = int'(gcn_read_address);
        if (m_a < 3) begin
          for (int i = 0; i < 96; i++) m_data[i] = ELEM_WIDTH'(m_wm[m_a][i]);
        end else if (m_a >= 512 && m_a < 518) begin
          for (int i = 0; i < 96; i++) m_data[i] = ELEM_WIDTH'(m_fm[m_a - 512][i]);
        end else begin
          m_data = '0;
          m_err  = 1'b1;
        end
      end
      if (int'(gcn_coo_address) >= 6) m_err = 1'b1;
      case (m_phase)
        0: if (load_valid) begin
          m_k = m_beats;
          if (m_k < 288)      m_wm[m_k / 96][m_k % 96] = int'(load_data);
          else if (m_k < 864) m_fm[(m_k - 288) / 96][(m_k - 288) % 96] = int'(load_data);
          else                m_coo[(m_k - 864) / 6][(m_k - 864) % 6] = int'(load_data) % 8;
          m_beats++;
          if (m_beats == 876) m_phase = 1;
        end
        1: m_phase = 2;
        2: if (gcn_done && !m_prev_done) begin
          m_result = gcn_max_addi_answer;
          m_phase  = 3;
        end
        default: if (result_ack) begin
          m_beats = 0;
          m_phase = 0;
        end
      endcase
      m_prev_done = gcn_done;
    end
  end

  always @(posedge clk) begin
    #1;
    check_output("cmp_load_ready", load_ready, m_phase == 0);
    check_output("cmp_gcn_start", gcn_start, m_phase == 1);
    check_output("cmp_result_valid", result_valid, m_phase == 3);
    check_output("cmp_result", result, m_result);
    check_output("cmp_data_in", gcn_data_in, m_data);
    check_output("cmp_addr_error", addr_error, m_err);
    cmp_a = int'(gcn_coo_address);
    if (cmp_a >= 6) begin
      check_output("cmp_coo_oob", gcn_coo_in, 6'd0);
    end else if (m_coo[0][cmp_a] >= 0 && m_coo[1][cmp_a] >= 0) begin
      check_output("cmp_coo", gcn_coo_in, {3'(m_coo[0][cmp_a]), 3'(m_coo[1][cmp_a])});
    end
    if (gcn_start === 1'b1) start_pulses++;
  end

  task automatic apply_stimulus(input int seed, input bit stalls, input int beats);
    for (int k = 0; k < beats; k++) begin
      if (stalls && (k % 97) == 13) begin
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = 5'd31;
        @(posedge clk);
      end
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = elem_value(k, seed);
      @(posedge clk);
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic read_row(input logic [ADDRESS_WIDTH-1:0] addr);
    @(negedge clk);
    gcn_enable_read  = 1'b1;
    gcn_read_address = addr;
    @(posedge clk);
    #1;
  endtask

  row_t exp_row;

  initial begin
    reset               = 1'b0;
    load_valid          = 1'b0;
    load_data           = '0;
    gcn_enable_read     = 1'b0;
    gcn_read_address    = '0;
    gcn_coo_address     = '0;
    gcn_done            = 1'b0;
    gcn_max_addi_answer = '0;
    result_ack          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_load_ready", load_ready, 1'b1);
    check_output("rst_gcn_start", gcn_start, 1'b0);
    check_output("rst_result_valid", result_valid, 1'b0);
    check_output("rst_data_in", gcn_data_in, '0);
    check_output("rst_addr_error", addr_error, 1'b0);

    // First load with stalls; stray load_valid afterwards must be ignored.
    apply_stimulus(0, 1'b1, 876);
    #1;
    check_output("start_after_last_beat", gcn_start, 1'b1);
    check_output("not_ready_in_start", load_ready, 1'b0);
    load_valid = 1'b1;
    load_data  = 5'd31;
    @(posedge clk);
    #1;
    check_output("start_one_cycle", gcn_start, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_valid = 1'b0;
    check_output("start_pulse_count1", start_pulses, 1);

    read_row(13'd1);
    for (int i = 0; i < 96; i++) exp_row[i] = ELEM_WIDTH'((1 + i) % 32);
    check_output("read_weight_col1", gcn_data_in, exp_row);
    read_row(13'd514);
    check_output("read_feature_row2", gcn_data_in, {96{5'd7}});
    @(negedge clk);
    gcn_enable_read  = 1'b0;
    gcn_read_address = 13'd3;
    @(posedge clk);
    #1;
    check_output("read_hold", gcn_data_in, {96{5'd7}});
    check_output("no_error_when_idle", addr_error, 1'b0);
    read_row(13'd3);
    check_output("read_unmapped", gcn_data_in, '0);
    check_output("addr_error_row", addr_error, 1'b1);
    read_row(13'd2);
    for (int i = 0; i < 96; i++) exp_row[i] = ELEM_WIDTH'((2 + i) % 32);
    check_output("read_weight_col2", gcn_data_in, exp_row);

    @(negedge clk);
    gcn_enable_read = 1'b0;
    gcn_coo_address = 3'd5;
    #1;
    check_output("coo_col5", gcn_coo_in, {3'd5, 3'd0});
    @(negedge clk);
    gcn_coo_address = 3'd2;
    #1;
    check_output("coo_col2", gcn_coo_in, {3'd2, 3'd3});
    gcn_coo_address = 3'd0;

    @(negedge clk);
    gcn_max_addi_answer = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
    gcn_done            = 1'b1;
    @(posedge clk);
    #1;
    check_output("result_capture", result, {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0});
    check_output("result_valid_set", result_valid, 1'b1);
    @(negedge clk);
    gcn_max_addi_answer = {6{2'd3}};
    repeat (2) @(posedge clk);
    #1;
    check_output("no_recapture", result, {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0});
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    check_output("ack_to_load", load_ready, 1'b1);
    check_output("ack_clears_valid", result_valid, 1'b0);
    check_output("result_retained", result, {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0});
    @(negedge clk);
    result_ack = 1'b0;

    // Second load while gcn_done stays high from the previous run.
    apply_stimulus(5, 1'b0, 876);
    #1;
    check_output("start_second", gcn_start, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_output("level_done_ignored", result_valid, 1'b0);
    read_row(13'd0);
    for (int i = 0; i < 96; i++) exp_row[i] = ELEM_WIDTH'((5 + i) % 32);
    check_output("reload_col0", gcn_data_in, exp_row);
    @(negedge clk);
    check_output("start_pulse_count2", start_pulses, 2);

    // Reset during RUN, then during a partial load.
    reset           = 1'b0;
    gcn_done        = 1'b0;
    gcn_enable_read = 1'b0;
    #1;
    check_output("midrun_load_ready", load_ready, 1'b1);
    check_output("midrun_result_valid", result_valid, 1'b0);
    check_output("midrun_result", result, '0);
    check_output("midrun_addr_error", addr_error, 1'b0);
    check_output("midrun_data_in", gcn_data_in, '0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(20, 1'b0, 100);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    apply_stimulus(9, 1'b1, 876);
    #1;
    check_output("start_third", gcn_start, 1'b1);
    read_row(13'd0);
    for (int i = 0; i < 96; i++) exp_row[i] = ELEM_WIDTH'((9 + i) % 32);
    check_output("restart_from_zero", gcn_data_in, exp_row);
    read_row(13'd517);
    check_output("read_feature_row5", gcn_data_in, {96{5'd16}});
    @(negedge clk);
    gcn_enable_read = 1'b0;
    check_output("start_pulse_count3", start_pulses, 3);
    check_output("no_error_before_coo", addr_error, 1'b0);
    gcn_coo_address = 3'd7;
    #1;
    check_output("coo_oob_zero", gcn_coo_in, 6'd0);
    @(posedge clk);
    #1;
    check_output("addr_error_coo", addr_error, 1'b1);
    @(negedge clk);
    gcn_coo_address     = 3'd0;
    gcn_max_addi_answer = {2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    gcn_done            = 1'b1;
    @(posedge clk);
    #1;
    check_output("result_capture3", result, {2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0});
    @(negedge clk);
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    check_output("ack_to_load3", load_ready, 1'b1);
    @(negedge clk);
    result_ack = 1'b0;
    gcn_done   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gcn_input_server.md
Name: gcn_input_server

Overview:
- Upstream stage feeding the GCN top.
- Accepts a serial element stream containing the weight matrix, the feature matrix and the COO adjacency list, and stores it locally.
- Pulses GCN start, then serves GCN's row reads and COO column reads.
- Captures GCN's per-node argmax answers on completion and presents them with a valid/ack handshake.

Parameters:
- FEATURE_ROWS, 6, number of nodes (feature rows).
- WEIGHT_ROWS, 96, elements per served row (equals FEATURE_COLS).
- WEIGHT_COLS, 3, weight columns served.
- ELEM_WIDTH, 5, bits per FM/WM element.
- ADDRESS_WIDTH, 13, GCN read-address width.
- FEATURE_BASE, 512, address of feature row 0; weight column c is at address c.
- COO_NUM_OF_COLS, 6, COO edge count.
- COO_BW, $clog2(COO_NUM_OF_COLS), COO entry/address width.
- MAX_ADDRESS_WIDTH, 2, argmax answer width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- load_valid  in  1  stream element valid
- load_data  in  ELEM_WIDTH  stream element; COO entries use the low COO_BW bits
- load_ready  out  1  stream accept
- gcn_start  out  1  one-cycle start pulse to GCN
- gcn_enable_read  in  1  GCN read strobe
- gcn_read_address  in  ADDRESS_WIDTH  GCN row address
- gcn_data_in  out  ELEM_WIDTH x [0:WEIGHT_ROWS-1]  served row
- gcn_coo_address  in  COO_BW  COO column requested
- gcn_coo_in  out  COO_BW x [0:1]  COO row0/row1 at that column
- gcn_done  in  1  GCN done
- gcn_max_addi_answer  in  MAX_ADDRESS_WIDTH x [0:FEATURE_ROWS-1]  GCN result
- result  out  MAX_ADDRESS_WIDTH x [0:FEATURE_ROWS-1]  captured answers
- result_valid  out  1  result held valid
- result_ack  in  1  consumer acknowledge
- addr_error  out  1  sticky: out-of-map read seen

Behaviour:
- Reset (async, reset=0): state LOAD, load counter 0, gcn_start=0, gcn_data_in all 0, result all 0, result_valid=0, addr_error=0. Storage contents are not cleared.
- Stream order, TOTAL = WEIGHT_ROWS*WEIGHT_COLS + WEIGHT_ROWS*FEATURE_ROWS + 2*COO_NUM_OF_COLS = 876:
  - weight col 0 elems 0..95, then col 1, then col 2;
  - feature row 0 elems 0..95 through row 5;
  - COO row0 cols 0..5, then COO row1 cols 0..5.
- LOAD: load_ready=1. Each valid&ready beat writes one element and increments the counter. The beat at count TOTAL-1 moves the FSM to START.
- START: gcn_start=1 for exactly one cycle, then RUN. load_ready=0 in every state except LOAD.
- RUN: a rising edge of gcn_done (gcn_done=1 while last-cycle gcn_done=0) latches gcn_max_addi_answer into result, sets result_valid=1 and moves to HOLD. A level-high gcn_done left over from a prior run is ignored.
- HOLD: result and result_valid are held stable. result_ack=1 clears result_valid, clears the counter and returns to LOAD. The result values themselves are retained.
- Row read: if gcn_enable_read=1 at a clock edge, gcn_data_in updates at that edge; latency is 1 cycle.
  - Address c < WEIGHT_COLS: weight column c.
  - Address FEATURE_BASE+r with r < FEATURE_ROWS: feature row r.
  - Any other address: all zeros, and addr_error is set (sticky until reset).
  - gcn_data_in holds its value when gcn_enable_read=0.
- Reads are served in every state. A read of a row that is being written in the same cycle returns the old contents.
- COO read is combinational: gcn_coo_in[0]=row0[gcn_coo_address], gcn_coo_in[1]=row1[gcn_coo_address]. An address ≥ COO_NUM_OF_COLS returns 0 and sets addr_error.
- Reset mid-LOAD or mid-RUN: the FSM returns to LOAD and the next stream overwrites from element 0. GCN shares the reset.
- load_valid in any non-LOAD state is ignored and consumes no beat.

Decomposition:
- Shared package gcn_pkg holds:
  - state enum {LOAD, START, RUN, HOLD};
  - constants TOTAL, FEATURE_BASE;
  - the row type (ELEM_WIDTH x WEIGHT_ROWS).
- Natural sub-module gcn_row_store: WEIGHT_COLS+FEATURE_ROWS rows, element-granular write port, registered full-row read port with out-of-map detect.
- The COO storage and the FSM live in the top.

Test Plan:
- Reset sequencing: hold reset=0 for 3 cycles, release → load_ready=1, gcn_start=0, result_valid=0, gcn_data_in all 0.
- Load and start: stream 876 beats (weight col c elem i = (c+i)%32, features = 7, COO row0={0,1,2,3,4,5}, row1={1,2,3,4,5,0}) → exactly one gcn_start pulse the cycle after the last beat, load_ready=0 thereafter.
- Row serving: enable_read with address 1 → next cycle gcn_data_in[i]=(1+i)%32. Address 514 → all 7. Address 3 → all 0 and addr_error=1.
- COO serving: gcn_coo_address=5 → gcn_coo_in={5,0} in the same cycle.
- Done capture: in RUN drive gcn_max_addi_answer={2,1,0,2,1,0} and raise gcn_done → result equals those values and result_valid=1. Holding gcn_done high causes no re-capture. result_ack returns to LOAD with load_ready=1.
- Stall and mid-run reset: insert load_valid=0 gaps during the load → beat count unaffected. Assert reset during RUN → state LOAD, result_valid=0, next load starts at element 0.
